// File: rtl/dnn_sdram_responder.sv
// Avalon-MM word RAM responder standing in for SDRAM behind the dnn master.
// Optional LFSR-randomised stall length when DNN_RESP_RANDOM_WAIT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no request seen yet; first request cycle lands here
// ST_STALL  | request held, counting stall cycles up to the target
// ST_ACCEPT | waitrequest may drop this cycle; held here on read back-pressure
module dnn_sdram_responder #(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          WAIT_CYCLES  = 1,
  parameter int          READ_LATENCY = 2,
  parameter int          MAX_PENDING  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_ACCEPT} state_t;

  state_t        state, state_next;
  logic [15:0]   stall_cnt, stall_cnt_next, stall_target;
  logic [PW-1:0] pending;
  logic          req, is_wr, is_rd, slot_free;
  logic          accept, acc_rd, acc_wr;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   offset;
  logic [1:0]    unused_offset_lsb;
  logic [29:0]   word_full;
  logic          below_base, in_range;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;

  logic          pipe_v [READ_LATENCY];
  logic [31:0]   pipe_d [READ_LATENCY];

  assign req   = s_read | s_write;
  assign is_wr = s_write;
  assign is_rd = s_read & ~s_write;

  // Byte offset from the base; the two byte-lane bits never select a word.
  assign offset            = s_address - ADDR_BASE;
  assign unused_offset_lsb = offset[1:0];
  assign word_full         = offset[31:2];
  assign below_base        = s_address < ADDR_BASE;
  assign in_range          = !below_base && (word_full < 30'(DEPTH_WORDS));
  assign word_idx          = word_full[AW-1:0];
  assign rd_word           = in_range ? ram[word_idx] : 32'hDEAD_BEEF;

`ifdef DNN_RESP_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  assign stall_target = {8'h00, lfsr[7:0]} % 16'(WAIT_CYCLES + 1);
`else
  assign stall_target = 16'(WAIT_CYCLES);
`endif

  // A read completing this cycle releases its slot to the read being accepted.
  assign slot_free = (pending != PW'(MAX_PENDING)) || s_readdatavalid;

  always_comb begin
    state_next     = state;
    stall_cnt_next = stall_cnt;
    accept         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!req) begin
          stall_cnt_next = '0;
        end else if (stall_target == 16'd0) begin
          state_next     = ST_ACCEPT;
          stall_cnt_next = '0;
        end else begin
          state_next     = ST_STALL;
          stall_cnt_next = 16'd1;
        end
      end
      ST_STALL: begin
        if (!req) begin
          state_next     = ST_IDLE;
          stall_cnt_next = '0;
        end else if (stall_cnt == stall_target) begin
          state_next     = ST_ACCEPT;
          stall_cnt_next = '0;
        end else begin
          stall_cnt_next = stall_cnt + 16'd1;
        end
      end
      ST_ACCEPT: begin
        stall_cnt_next = '0;
        if (!req) begin
          state_next = ST_IDLE;
        end else if (is_wr || slot_free) begin
          accept     = rst_n;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next     = ST_IDLE;
        stall_cnt_next = '0;
      end
    endcase
  end

  assign s_waitrequest = ~accept;
  assign acc_rd        = accept & is_rd;
  assign acc_wr        = accept & is_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      stall_cnt <= '0;
      pending   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      case ({acc_rd, s_readdatavalid})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
      if (accept && (!in_range || (s_read && s_write))) begin
        err <= 1'b1;
      end
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (acc_wr && in_range) begin
      ram[word_idx] <= s_writedata;
    end
  end

  // Data only moves with its valid bit, so the last stage holds the last return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= acc_rd;
      if (acc_rd) begin
        pipe_d[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign s_readdatavalid = pipe_v[READ_LATENCY-1];
  assign s_readdata      = pipe_d[READ_LATENCY-1];

endmodule
